// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM encoding and op classification for alu_secuencial
package alu_pkg;

   localparam logic [2:0] OP_SUM = 3'b000;
   localparam logic [2:0] OP_RES = 3'b001;
   localparam logic [2:0] OP_PRO = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_MOD = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_OR  = 3'b110;
   localparam logic [2:0] OP_XOR = 3'b111;

   localparam logic [1:0] LIBRE   = 2'd0;
   localparam logic [1:0] CALCULA = 2'd1;
   localparam logic [1:0] ENTREGA = 2'd2;

   // Division by zero short-circuits to a one-cycle answer.
   function automatic logic es_iterativo(input logic [2:0] op,
                                         input logic       mult_iter,
                                         input logic       divisor_cero);
      return ((op == OP_DIV || op == OP_MOD) && !divisor_cero) ||
             (op == OP_PRO && mult_iter);
   endfunction

endpackage

// File: rtl/divisor_iterativo.sv
// rtl/divisor_iterativo.sv - restoring divider, one quotient bit per step of the shared counter
module divisor_iterativo #(
   parameter int ANCHO = 8
) (
   input  logic                   reloj,
   input  logic                   reinicio,
   input  logic                   inicio_i,
   input  logic                   paso_i,
   input  logic [ANCHO-1:0]       dividendo_i,
   input  logic [ANCHO-1:0]       divisor_i,
   input  logic [$clog2(ANCHO):0] cuenta_i,
   output logic [ANCHO-1:0]       cociente_o,
   output logic [ANCHO-1:0]       residuo_o,
   output logic                   fin_o
);

   localparam int CW = $clog2(ANCHO) + 1;
   localparam logic [CW-1:0] CUENTA_FIN = CW'(ANCHO - 1);

   logic [ANCHO-1:0] resto_q, resto_d;
   logic [ANCHO-1:0] cociente_q, cociente_d;
   logic [ANCHO-1:0] divisor_q;
   logic [ANCHO:0]   desplazado, diferencia;

   always_comb begin
      desplazado = {resto_q, cociente_q[ANCHO-1]};
      diferencia = desplazado - {1'b0, divisor_q};
      if (diferencia[ANCHO]) begin
         resto_d    = desplazado[ANCHO-1:0];
         cociente_d = {cociente_q[ANCHO-2:0], 1'b0};
      end else begin
         resto_d    = diferencia[ANCHO-1:0];
         cociente_d = {cociente_q[ANCHO-2:0], 1'b1};
      end
   end

   always_ff @(posedge reloj) begin
      if (reinicio) begin
         resto_q    <= '0;
         cociente_q <= '0;
         divisor_q  <= '0;
      end else if (inicio_i) begin
         resto_q    <= '0;
         cociente_q <= dividendo_i;
         divisor_q  <= divisor_i;
      end else if (paso_i) begin
         resto_q    <= resto_d;
         cociente_q <= cociente_d;
      end
   end

   // The last step is taken combinationally so the result lands on the final counter edge.
   assign cociente_o = cociente_d;
   assign residuo_o  = resto_d;
   assign fin_o      = (cuenta_i == CUENTA_FIN);

endmodule

// File: rtl/alu_secuencial.sv
// rtl/alu_secuencial.sv - multi-cycle ALU with valid/ready handshakes and iterative DIV/MOD/PRO
module alu_secuencial
   import alu_pkg::*;
#(
   parameter int ANCHO     = 8,
   parameter int MULT_ITER = 1
) (
   input  logic                 reloj,
   input  logic                 reinicio,
   input  logic                 entrada_valida,
   output logic                 entrada_lista,
   input  logic [2:0]           Codigo_OP,
   input  logic [ANCHO-1:0]     Dato0,
   input  logic [ANCHO-1:0]     Dato1,
   output logic [2*ANCHO-1:0]   Resultado,
   output logic                 resultado_valido,
   input  logic                 resultado_listo,
   output logic                 banderaA,
   output logic                 banderaB,
   output logic                 banderaC
);

   localparam int   CW           = $clog2(ANCHO) + 1;
   localparam logic MULT_ES_ITER = (MULT_ITER != 0);

   logic [1:0]         estado_q, estado_d;
   logic [2:0]         op_q, op_d;
   logic [CW-1:0]      cuenta_q, cuenta_d;
   logic [2*ANCHO-1:0] resultado_q, resultado_d;
   logic               banderaA_q, banderaA_d;
   logic               banderaB_q, banderaB_d;
   logic               banderaC_q, banderaC_d;

   logic               acepta, paso, fin_calculo, divisor_cero;
   logic [ANCHO-1:0]   cociente, residuo;
   logic [2*ANCHO-1:0] producto_iter, producto_comb;
   logic [2*ANCHO+1:0] salida_acepta, salida_fin;

   // Packs {banderaC, banderaA, Resultado}; banderaB is derived from the result by the caller.
   function automatic logic [2*ANCHO+1:0] calcula(input logic [2:0]         op,
                                                  input logic [ANCHO-1:0]   a,
                                                  input logic [ANCHO-1:0]   b,
                                                  input logic [2*ANCHO-1:0] prod,
                                                  input logic [ANCHO-1:0]   coc,
                                                  input logic [ANCHO-1:0]   res,
                                                  input logic               cero);
      logic [ANCHO:0]     suma, resta;
      logic [2*ANCHO-1:0] r;
      logic               fa;
      suma  = {1'b0, a} + {1'b0, b};
      resta = {1'b0, a} - {1'b0, b};
      r     = '0;
      fa    = 1'b0;
      case (op)
         OP_SUM: begin r = {{(ANCHO-1){1'b0}}, suma}; fa = suma[ANCHO]; end
         OP_RES: begin r[ANCHO-1:0] = resta[ANCHO-1:0]; fa = resta[ANCHO]; end
         OP_PRO: begin r = prod; fa = |prod[2*ANCHO-1:ANCHO]; end
         OP_DIV: r[ANCHO-1:0] = coc;
         OP_MOD: r[ANCHO-1:0] = res;
         OP_AND: r[ANCHO-1:0] = a & b;
         OP_OR:  r[ANCHO-1:0] = a | b;
         OP_XOR: r[ANCHO-1:0] = a ^ b;
         default: r = '0;
      endcase
      return {cero && (op == OP_DIV || op == OP_MOD), fa, r};
   endfunction

   assign divisor_cero  = (Dato1 == '0);
   assign entrada_lista = (estado_q == LIBRE) && !reinicio;
   assign acepta        = entrada_valida && entrada_lista;
   assign paso          = (estado_q == CALCULA);
   assign producto_comb = (2*ANCHO)'(Dato0) * (2*ANCHO)'(Dato1);

   // At accept the DIV/MOD inputs already carry the divide-by-zero answers.
   assign salida_acepta = calcula(Codigo_OP, Dato0, Dato1, producto_comb, '1, Dato0, divisor_cero);
   assign salida_fin    = calcula(op_q, '0, '0, producto_iter, cociente, residuo, 1'b0);

   divisor_iterativo #(.ANCHO(ANCHO)) u_divisor (
      .reloj       (reloj),
      .reinicio    (reinicio),
      .inicio_i    (acepta),
      .paso_i      (paso),
      .dividendo_i (Dato0),
      .divisor_i   (Dato1),
      .cuenta_i    (cuenta_q),
      .cociente_o  (cociente),
      .residuo_o   (residuo),
      .fin_o       (fin_calculo)
   );

   generate
      if (MULT_ITER != 0) begin : g_mult_iter
         logic [ANCHO-1:0]   multiplicando_q;
         logic [2*ANCHO-1:0] producto_q;
         logic [ANCHO:0]     suma_parcial;

         // Upper half accumulates, lower half shifts the multiplier out LSB first.
         assign suma_parcial  = {1'b0, producto_q[2*ANCHO-1:ANCHO]} +
                                (producto_q[0] ? {1'b0, multiplicando_q} : '0);
         assign producto_iter = {suma_parcial, producto_q[ANCHO-1:1]};

         always_ff @(posedge reloj) begin
            if (reinicio) begin
               multiplicando_q <= '0;
               producto_q      <= '0;
            end else if (acepta) begin
               multiplicando_q <= Dato0;
               producto_q      <= {{ANCHO{1'b0}}, Dato1};
            end else if (paso) begin
               producto_q <= producto_iter;
            end
         end
      end else begin : g_mult_comb
         assign producto_iter = '0;
      end
   endgenerate

   always_comb begin
      estado_d    = estado_q;
      op_d        = op_q;
      cuenta_d    = cuenta_q;
      resultado_d = resultado_q;
      banderaA_d  = banderaA_q;
      banderaB_d  = banderaB_q;
      banderaC_d  = banderaC_q;
      case (estado_q)
         LIBRE: begin
            if (acepta) begin
               op_d     = Codigo_OP;
               cuenta_d = '0;
               if (es_iterativo(Codigo_OP, MULT_ES_ITER, divisor_cero)) begin
                  estado_d = CALCULA;
               end else begin
                  estado_d = ENTREGA;
                  {banderaC_d, banderaA_d, resultado_d} = salida_acepta;
                  banderaB_d = (salida_acepta[2*ANCHO-1:0] == '0);
               end
            end
         end
         CALCULA: begin
            if (fin_calculo) begin
               estado_d = ENTREGA;
               {banderaC_d, banderaA_d, resultado_d} = salida_fin;
               banderaB_d = (salida_fin[2*ANCHO-1:0] == '0);
            end else begin
               cuenta_d = cuenta_q + 1'b1;
            end
         end
         ENTREGA: begin
            if (resultado_listo) estado_d = LIBRE;
         end
         default: estado_d = LIBRE;
      endcase
   end

   always_ff @(posedge reloj) begin
      if (reinicio) begin
         estado_q    <= LIBRE;
         op_q        <= OP_SUM;
         cuenta_q    <= '0;
         resultado_q <= '0;
         banderaA_q  <= 1'b0;
         banderaB_q  <= 1'b0;
         banderaC_q  <= 1'b0;
      end else begin
         estado_q    <= estado_d;
         op_q        <= op_d;
         cuenta_q    <= cuenta_d;
         resultado_q <= resultado_d;
         banderaA_q  <= banderaA_d;
         banderaB_q  <= banderaB_d;
         banderaC_q  <= banderaC_d;
      end
   end

   assign Resultado        = resultado_q;
   assign resultado_valido = (estado_q == ENTREGA);
   assign banderaA         = banderaA_q;
   assign banderaB         = banderaB_q;
   assign banderaC         = banderaC_q;

endmodule
